// File: rtl/spi_master.sv
// SPI initiator: full-duplex, MSB-first DATA_WIDTH-bit frames with runtime CPOL/CPHA.
// Optional SPI_MASTER_BURST_EN: start in the last HOLD cycle chains the next byte in the same ss frame.
module spi_master #(
  parameter int unsigned CLK_FREQUENCE = 50_000_000,
  parameter int unsigned SPI_FREQUENCE = 5_000_000,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  CPOL,
  input  logic                  CPHA,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  sclk,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned HALF   = CLK_FREQUENCE / (2 * SPI_FREQUENCE);
  localparam int unsigned CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH);

  if (HALF < 2) begin : g_half_chk
    $error("spi_master: CLK_FREQUENCE/(2*SPI_FREQUENCE) must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [EDGE_W-1:0]     edge_q, edge_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
  logic                  half_end_c, last_edge_c, burst_go_c;

  assign half_end_c  = (cnt_q == CNT_W'(HALF - 1));
  assign last_edge_c = (edge_q == EDGE_W'(2 * DATA_WIDTH - 1));

`ifdef SPI_MASTER_BURST_EN
  assign burst_go_c = start;
`else
  assign burst_go_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = half_end_c ? '0 : cnt_q + CNT_W'(1);
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        edge_d = '0;
        sclk_d = CPOL;
        ss_d   = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = SETUP;
          tx_d    = datain;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = CPHA ? 1'b0 : datain[DATA_WIDTH-1];
        end
      end
      SETUP: begin
        if (half_end_c) state_d = XFER;
      end
      XFER: begin
        if (half_end_c) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          // even edge_q = leading edge; sample edge parity matches cpha
          if (edge_q[0] == cpha_q) begin
            rx_d = {rx_q[DATA_WIDTH-2:0], miso};
          end else if (!cpha_q && !last_edge_c) begin
            mosi_d = tx_q[DATA_WIDTH-2];
            tx_d   = tx_q << 1;
          end
          if (cpha_q && !edge_q[0]) begin
            mosi_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end
          if (last_edge_c) begin
            state_d = HOLD;
            edge_d  = '0;
          end
        end
      end
      HOLD: begin
        sclk_d = cpol_q;
        if (half_end_c) begin
          done_d = 1'b1;
          dout_d = rx_q;
          if (burst_go_c) begin
            state_d = SETUP;
            tx_d    = datain;
            mosi_d  = cpha_q ? 1'b0 : datain[DATA_WIDTH-1];
          end else begin
            state_d = GAP;
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
          end
        end
      end
      GAP: begin
        ss_d = 1'b1;
        if (half_end_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= CPOL;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataout = dout_q;
  assign sclk    = sclk_q;
  assign ss      = ss_q;
  assign mosi    = mosi_q;

endmodule
